// File: rtl/core_pkg.sv
// Shared sequencer definitions: state encodings, channel-index width and parameter bounds.
package core_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_MEM    = 4'd3,
        ST_WB     = 4'd4,
        ST_IO_OUT = 4'd5,
        ST_IO_IN  = 4'd6
    } seq_state_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;
    localparam int N_IO_MIN    = 1;
    localparam int N_IO_MAX    = 8;

    // Wide enough to index N_IO_MAX channels.
    localparam int CH_W = 3;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index request select: one-hot grant plus binary index of the winning bit.
// Latency: combinational. Backpressure: none, pure decode of req.
// All-zero req gives onehot=0, idx=0.
module prio_enc
    import core_pkg::*;
#(
    parameter int N = 2
)(
    input  logic [N-1:0]    req,
    output logic [N-1:0]    onehot,
    output logic [CH_W-1:0] idx
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = req & (~req + N'(1));

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = CH_W'(i);
        end
    end

endmodule

// File: rtl/multicycle_seq.sv
// Multicycle instruction sequencer with byte I/O channels; SEQ_PERF_CNT_EN adds cyc_cnt/instret.
// Latency: FETCH and MEM take MEM_LAT cycles each, other states one cycle unless waiting on I/O.
// Backpressure: IO_OUT stalls on tx_busy[ch], IO_IN stalls until rx_ready[ch], EXEC stalls until a request or dec_ready.
module multicycle_seq
    import core_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              N_IO     = 2,
    parameter int              MEM_LAT  = 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_ready,
    input  logic [N_IO-1:0]   out_req,
    input  logic [N_IO-1:0]   in_req,
    input  logic [N_IO-1:0]   tx_busy,
    input  logic [N_IO-1:0]   rx_ready,
    input  logic [8*N_IO-1:0] rx_data,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_addr,
    output logic [PC_W-1:0]   pc,
    output logic [3:0]        state,
    output logic              mem_en,
    output logic              mem_sel_data,
    output logic              wb_en,
    output logic              in_valid,
    output logic [31:0]       in_data,
    output logic [N_IO-1:0]   tx_start
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       instret
`endif
);

    seq_state_t      state_q, state_d;
    logic [3:0]      wait_cnt;
    logic [N_IO-1:0] ch_oh;
    logic [CH_W-1:0] ch_idx;
    logic [N_IO-1:0] pe_req, pe_oh;
    logic [CH_W-1:0] pe_idx;
    logic            wait_done, ch_busy, ch_rx;
    logic [7:0]      rx_byte;

    // Output requests outrank input requests, so the encoder sees whichever class wins.
    assign pe_req = (|out_req) ? out_req : in_req;

    prio_enc #(.N(N_IO)) u_prio_enc (
        .req    (pe_req),
        .onehot (pe_oh),
        .idx    (pe_idx)
    );

    assign wait_done = (wait_cnt == 4'(MEM_LAT - 1));
    assign ch_busy   = |(tx_busy & ch_oh);
    assign ch_rx     = |(rx_ready & ch_oh);

    always_comb begin
        rx_byte = '0;
        for (int i = 0; i < N_IO; i++) begin
            if (ch_idx == CH_W'(i)) rx_byte = rx_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (wait_done) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (|out_req)      state_d = ST_IO_OUT;
                else if (|in_req)  state_d = ST_IO_IN;
                else if (dec_ready) state_d = ST_MEM;
            end
            ST_IO_OUT: if (!ch_busy) state_d = ST_MEM;
            ST_IO_IN:  if (ch_rx)    state_d = ST_MEM;
            ST_MEM:    if (wait_done) state_d = ST_WB;
            ST_WB:     state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            wait_cnt <= '0;
            ch_oh    <= '0;
            ch_idx   <= '0;
            in_valid <= 1'b0;
            in_data  <= '0;
            tx_start <= '0;
        end else begin
            tx_start <= '0;
            if ((state_q == ST_FETCH || state_q == ST_MEM) && !wait_done)
                wait_cnt <= wait_cnt + 4'd1;
            else
                wait_cnt <= '0;
            if (state_q == ST_EXEC && ((|out_req) || (|in_req))) begin
                ch_oh  <= pe_oh;
                ch_idx <= pe_idx;
            end
            if (state_q == ST_IO_OUT && !ch_busy)
                tx_start <= ch_oh;
            if (state_q == ST_IO_IN && ch_rx) begin
                in_valid <= 1'b1;
                in_data  <= {24'b0, rx_byte};
            end
            if (state_q == ST_WB) begin
                pc       <= br_taken ? br_addr : pc + PC_W'(4);
                in_valid <= 1'b0;
                in_data  <= '0;
            end
        end
    end

    assign state        = state_q;
    assign mem_en       = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign mem_sel_data = (state_q == ST_MEM);
    assign wb_en        = (state_q == ST_WB);

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
            instret <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (state_q == ST_WB) instret <= instret + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_seq.sv
// Scoreboard bench for multicycle_seq: MEM_LAT=1 instance for function, MEM_LAT=3 instance for timing.
module tb_multicycle_seq;

    localparam int N_IO = 2;

    typedef struct {
        logic [31:0] pc;
        logic        iv;
        logic [31:0] id;
    } exp_t;

    logic              clk, rst, dec_ready, dec_ready3, br_taken;
    logic [N_IO-1:0]   out_req, in_req, tx_busy, rx_ready;
    logic [8*N_IO-1:0] rx_data;
    logic [31:0]       br_addr;

    logic [31:0]     pc, in_data, pc3, in_data3;
    logic [3:0]      state, state3;
    logic            mem_en, mem_sel_data, wb_en, in_valid;
    logic            mem_en3, mem_sel_data3, wb_en3, in_valid3;
    logic [N_IO-1:0] tx_start, tx_start3;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]     cyc_cnt, instret, cyc_cnt3, instret3;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb_q[$];
    logic [1:0]  tx_q[$];
    logic [31:0] exp_pc   = 32'h0;
    int          n_instr  = 0;
    logic        pc_pending = 1'b0;
    logic [31:0] pc_exp;

    multicycle_seq #(.PC_W(32), .RESET_PC(32'h0), .N_IO(N_IO), .MEM_LAT(1)) dut (
        .clk(clk), .rst(rst), .dec_ready(dec_ready), .out_req(out_req), .in_req(in_req),
        .tx_busy(tx_busy), .rx_ready(rx_ready), .rx_data(rx_data), .br_taken(br_taken),
        .br_addr(br_addr), .pc(pc), .state(state), .mem_en(mem_en), .mem_sel_data(mem_sel_data),
        .wb_en(wb_en), .in_valid(in_valid), .in_data(in_data), .tx_start(tx_start)
`ifdef SEQ_PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .instret(instret)
`endif
    );

    multicycle_seq #(.PC_W(32), .RESET_PC(32'h0), .N_IO(N_IO), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .dec_ready(dec_ready3), .out_req(out_req), .in_req(in_req),
        .tx_busy(tx_busy), .rx_ready(rx_ready), .rx_data(rx_data), .br_taken(br_taken),
        .br_addr(br_addr), .pc(pc3), .state(state3), .mem_en(mem_en3), .mem_sel_data(mem_sel_data3),
        .wb_en(wb_en3), .in_valid(in_valid3), .in_data(in_data3), .tx_start(tx_start3)
`ifdef SEQ_PERF_CNT_EN
        , .cyc_cnt(cyc_cnt3), .instret(instret3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_rec(input logic [31:0] npc, input logic iv, input logic [31:0] id);
        exp_t r;
        r.pc = npc;
        r.iv = iv;
        r.id = id;
        sb_q.push_back(r);
        exp_pc = npc;
        n_instr++;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, state, s);
    endtask

    task automatic run_instr(input logic bt, input logic [31:0] ba);
        br_taken = bt;
        br_addr  = ba;
        push_rec(bt ? ba : exp_pc + 32'd4, 1'b0, 32'h0);
        wait_state(4'd4, 20, "instr_reach_wb");
        @(negedge clk);
        chk("instr_back_fetch", state, 4'd0);
    endtask

    // Monitor: each WB retires the oldest expected instruction; tx_start pulses pop the tx queue.
    always @(negedge clk) begin
        exp_t r;
        if (pc_pending) begin
            chk("wb_pc", pc, pc_exp);
            pc_pending = 1'b0;
        end
        if (state == 4'd4) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", sb_q.size(), 1);
            end else begin
                r = sb_q.pop_front();
                chk("wb_in_valid", in_valid, r.iv);
                chk("wb_in_data", in_data, r.id);
                pc_exp     = r.pc;
                pc_pending = 1'b1;
            end
        end
        if (tx_start != '0) begin
            if (tx_q.size() == 0) chk("tx_unexpected", tx_start, 0);
            else chk("tx_start_pulse", tx_start, tx_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  seq_exp[5];
        logic [31:0] c0;
        int          n_fetch, n_mem, total;
        logic        seen_wb;

        rst = 1'b1; dec_ready = 1'b0; dec_ready3 = 1'b0; br_taken = 1'b0; br_addr = '0;
        out_req = '0; in_req = '0; tx_busy = '0; rx_ready = '0; rx_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", state, 4'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_in_valid", in_valid, 1'b0);
        chk("rst_in_data", in_data, 32'h0);
        chk("rst_tx_start", tx_start, 2'b00);
        chk("rst_mem_en", mem_en, 1'b1);

        // Plain instruction: 0,1,2,3,4,0 and pc 0 -> 4.
        seq_exp[0] = 4'd1; seq_exp[1] = 4'd2; seq_exp[2] = 4'd3; seq_exp[3] = 4'd4; seq_exp[4] = 4'd0;
        rst = 1'b0;
        dec_ready = 1'b1;
        push_rec(32'h4, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("seq_state", state, seq_exp[i]);
            chk("seq_mem_en", mem_en, (seq_exp[i] == 4'd0) || (seq_exp[i] == 4'd3));
            chk("seq_mem_sel", mem_sel_data, seq_exp[i] == 4'd3);
            chk("seq_wb_en", wb_en, seq_exp[i] == 4'd4);
        end
        chk("seq_pc", pc, 32'h4);

        // Branch to the top of the address space, wrap, then branch to 0x100.
        run_instr(1'b1, 32'hFFFF_FFFC);
        run_instr(1'b0, 32'h0000_0040);
        chk("wrap_pc", pc, 32'h0);
        run_instr(1'b1, 32'h0000_0100);
        chk("branch_pc", pc, 32'h100);
        run_instr(1'b0, 32'h0);
        br_taken = 1'b0;

        // Both channels request output, channel 0 busy for 5 cycles.
        out_req = 2'b11;
        tx_busy = 2'b01;
        push_rec(exp_pc + 32'd4, 1'b0, 32'h0);
        tx_q.push_back(2'b01);
        wait_state(4'd5, 10, "io_out_enter");
        out_req = '0;
        for (int i = 0; i < 5; i++) begin
            chk("io_out_hold", state, 4'd5);
            chk("io_out_no_tx", tx_start, 2'b00);
            if (i == 4) tx_busy = 2'b00;
            @(negedge clk);
        end
        chk("io_out_to_mem", state, 4'd3);
        chk("io_out_tx", tx_start, 2'b01);
        wait_state(4'd4, 10, "io_out_wb");
        @(negedge clk);

        // Input on channel 1; channel 0 rx_ready must be ignored.
        in_req = 2'b10;
        push_rec(exp_pc + 32'd4, 1'b1, 32'h0000_00A5);
        wait_state(4'd6, 10, "io_in_enter");
        in_req   = '0;
        rx_ready = 2'b01;
        rx_data  = 16'h5A77;
        for (int i = 0; i < 3; i++) begin
            chk("io_in_hold", state, 4'd6);
            chk("io_in_no_valid", in_valid, 1'b0);
            if (i == 2) begin
                rx_ready = 2'b11;
                rx_data  = 16'hA577;
            end
            @(negedge clk);
        end
        rx_ready = '0;
        chk("io_in_to_mem", state, 4'd3);
        chk("io_in_valid", in_valid, 1'b1);
        chk("io_in_data", in_data, 32'h0000_00A5);
        wait_state(4'd4, 10, "io_in_wb");
        @(negedge clk);
        dec_ready = 1'b0;
        chk("io_in_fetch_valid", in_valid, 1'b0);
        chk("io_in_fetch_data", in_data, 32'h0);

`ifdef SEQ_PERF_CNT_EN
        chk("perf_instret", instret, n_instr);
        c0 = cyc_cnt;
        repeat (10) @(negedge clk);
        chk("perf_cyc_delta", cyc_cnt - c0, 32'd10);
`else
        c0 = pc;
        repeat (10) @(negedge clk);
        chk("idle_pc_hold", pc, c0);
`endif

        // Reset while stalled in IO_IN.
        in_req = 2'b01;
        wait_state(4'd6, 20, "rst_io_in_enter");
        in_req = '0;
        repeat (2) @(negedge clk);
        chk("rst_io_in_wait", state, 4'd6);
        rst = 1'b1;
        @(negedge clk);
        exp_pc = 32'h0;
        chk("midrst_state", state, 4'd0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_in_valid", in_valid, 1'b0);
        chk("midrst_tx_start", tx_start, 2'b00);
`ifdef SEQ_PERF_CNT_EN
        chk("midrst_cyc_cnt", cyc_cnt, 32'h0);
        chk("midrst_instret", instret, 32'h0);
`endif

        // MEM_LAT=3 instance: FETCH and MEM held 3 cycles, 9 cycles per instruction.
        dec_ready3 = 1'b1;
        rst = 1'b0;
        n_fetch = 0; n_mem = 0; total = 0; seen_wb = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (seen_wb && state3 == 4'd0) break;
            total++;
            if (state3 == 4'd0) n_fetch++;
            if (state3 == 4'd3) n_mem++;
            if (state3 == 4'd4) seen_wb = 1'b1;
            @(negedge clk);
        end
        chk("lat3_fetch_cycles", n_fetch, 3);
        chk("lat3_mem_cycles", n_mem, 3);
        chk("lat3_total_cycles", total, 9);
        chk("lat3_pc", pc3, 32'h4);
        chk("lat1_stalled_exec", state, 4'd2);

        chk("sb_drain", sb_q.size(), 0);
        chk("tx_drain", tx_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
